// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker. It predicts each received bit from the previously received
// history, flags mismatches, tracks lock with a HUNT/LOCKED FSM and counts bit errors while locked.
module lfsr_prbs_check #(
  parameter int unsigned           LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter bit                    REVERSE      = 1'b0,
  parameter bit                    INVERT       = 1'b1,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           LOCK_COUNT   = 16,
  parameter int unsigned           UNLOCK_COUNT = 4,
  parameter int unsigned           COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   count_clear,
  output logic [DATA_WIDTH-1:0]  error_out,
  output logic                   error_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] error_count
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned PopW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SumW  = ((COUNT_WIDTH > PopW) ? COUNT_WIDTH : PopW) + 1;

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  if (LFSR_CONFIG != "FIBONACCI") begin : g_cfg_check
    $error("lfsr_prbs_check: only the FIBONACCI configuration is supported");
  end

  state_e                  state_q, state_d;
  logic [GoodW-1:0]        good_cnt_q, good_cnt_d;
  logic [BadW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [LFSR_WIDTH-1:0]   hist_q, hist_d, hist_new;
  logic [DATA_WIDTH-1:0]   error_out_q, error_out_d;
  logic                    error_valid_q, error_valid_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]   err_vec;
  logic                    rx_bit, pred_bit, word_err;
  logic [PopW-1:0]         err_pop;
  logic [SumW-1:0]         count_sum;

  // Bits are walked oldest first; hist_new[0] always holds the most recent bit so later bits
  // of the same word see earlier ones.
  always_comb begin
    hist_new = hist_q;
    err_vec  = '0;
    rx_bit   = 1'b0;
    pred_bit = 1'b0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      rx_bit   = data_in[REVERSE ? j : DATA_WIDTH - 1 - j] ^ INVERT;
      pred_bit = 1'b0;
      for (int i = 0; i < LFSR_WIDTH; i++) begin
        if (LFSR_POLY[i]) pred_bit = pred_bit ^ hist_new[LFSR_WIDTH - 1 - i];
      end
      err_vec[REVERSE ? j : DATA_WIDTH - 1 - j] = rx_bit ^ pred_bit;
      hist_new = {hist_new[LFSR_WIDTH-2:0], rx_bit};
    end
  end

  always_comb begin
    err_pop = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      err_pop = err_pop + PopW'(err_vec[j]);
    end
  end

  assign word_err = |err_vec;

  always_comb begin
    hist_d        = enable ? hist_new : hist_q;
    error_out_d   = enable ? err_vec : error_out_q;
    error_valid_d = enable;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (enable) begin
      case (state_q)
        StHunt: begin
          if (word_err) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GoodW'(LOCK_COUNT - 1)) begin
            state_d    = StLocked;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + GoodW'(1);
          end
        end
        StLocked: begin
          if (!word_err) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q == BadW'(UNLOCK_COUNT - 1)) begin
            state_d    = StHunt;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + BadW'(1);
          end
        end
        default: begin
          state_d    = StHunt;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
      endcase
    end
  end

  // Extra headroom bit in count_sum detects overflow for saturation.
  always_comb begin
    count_sum = SumW'(count_q) + SumW'(err_pop);
    count_d   = count_q;
    if (count_clear) begin
      count_d = '0;
    end else if (enable && state_q == StLocked) begin
      if (count_sum > SumW'({COUNT_WIDTH{1'b1}})) count_d = '1;
      else count_d = count_sum[COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      hist_q        <= '0;
      error_out_q   <= '0;
      error_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      hist_q        <= hist_d;
      error_out_q   <= error_out_d;
      error_valid_q <= error_valid_d;
      count_q       <= count_d;
    end
  end

  assign error_out   = error_out_q;
  assign error_valid = error_valid_q;
  assign locked      = (state_q == StLocked);
  assign error_count = count_q;

endmodule
